// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus symbol constants and a
// helper that turns a data bit into an open-drain pull-low request.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2cState_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // SDA is open drain: a 0 is sent by pulling low, a 1 by releasing.
    function automatic logic driveLow(input logic bitVal);
        return (bitVal == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Bus pins plus the register-backend handshake of the I2C target.
interface i2c_slave_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] o_wr_data;
    logic       o_wr_valid;
    logic       o_wr_first;
    logic       o_rd_req;
    logic [7:0] i_rd_data;
    logic       o_busy;
    logic       o_nack;

    modport slave (
        input  scl_i, sda_i, i_rd_data,
        output sda_oe, o_wr_data, o_wr_valid, o_wr_first, o_rd_req, o_busy, o_nack
    );

    modport master (
        output scl_i, sda_i, i_rd_data,
        input  sda_oe, o_wr_data, o_wr_valid, o_wr_first, o_rd_req, o_busy, o_nack
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the system clock domain and decodes SCL edges plus
// START/STOP conditions from the synchronized levels.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclDel_q;
    logic                   sdaDel_q;
    logic                   sclS;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            sclSync_q <= {SYNC_STAGES{1'b1}};
            sdaSync_q <= {SYNC_STAGES{1'b1}};
            sclDel_q  <= 1'b1;
            sdaDel_q  <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclDel_q  <= sclSync_q[SYNC_STAGES-1];
            sdaDel_q  <= sdaSync_q[SYNC_STAGES-1];
        end
    end

    assign sclS      = sclSync_q[SYNC_STAGES-1];
    assign sda_s     = sdaSync_q[SYNC_STAGES-1];
    assign scl_rise  = sclS & ~sclDel_q;
    assign scl_fall  = ~sclS & sclDel_q;
    assign start_det = sclS & sclDel_q & sdaDel_q & ~sda_s;
    assign stop_det  = sclS & sclDel_q & ~sdaDel_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; samples on SCL rise, changes SDA
// only on SCL fall, and exchanges bytes with a register backend.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h4B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        reset,
    i2c_slave_if.slave  bus
);

    logic sclRise, sclFall, startDet, stopDet, sdaS;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .i_clk     (i_clk),
        .reset     (reset),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet),
        .sda_s     (sdaS)
    );

    i2cState_e  state_q, state_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       phase_q, phase_d;
    logic       rdLoad_q, rdLoad_d;
    logic       sdaOe_q, sdaOe_d;
    logic       busy_q, busy_d;
    logic [7:0] wrData_q, wrData_d;
    logic       wrValid_q, wrValid_d;
    logic       wrFirst_q, wrFirst_d;
    logic       rdReq_q, rdReq_d;
    logic       nack_q, nack_d;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bitCnt_q  <= 3'd7;
            shift_q   <= 8'h00;
            rw_q      <= RW_WRITE;
            first_q   <= 1'b0;
            phase_q   <= 1'b0;
            rdLoad_q  <= 1'b0;
            sdaOe_q   <= 1'b0;
            busy_q    <= 1'b0;
            wrData_q  <= 8'h00;
            wrValid_q <= 1'b0;
            wrFirst_q <= 1'b0;
            rdReq_q   <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            phase_q   <= phase_d;
            rdLoad_q  <= rdLoad_d;
            sdaOe_q   <= sdaOe_d;
            busy_q    <= busy_d;
            wrData_q  <= wrData_d;
            wrValid_q <= wrValid_d;
            wrFirst_q <= wrFirst_d;
            rdReq_q   <= rdReq_d;
            nack_q    <= nack_d;
        end
    end

    // phase_q splits each ACK state into "drive on next fall" and
    // "release/hand over on the fall after that".
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        first_d   = first_q;
        phase_d   = phase_q;
        rdLoad_d  = 1'b0;
        sdaOe_d   = sdaOe_q;
        busy_d    = busy_q;
        wrData_d  = wrData_q;
        wrValid_d = 1'b0;
        wrFirst_d = wrFirst_q;
        rdReq_d   = 1'b0;
        nack_d    = 1'b0;

        if (rdLoad_q) begin
            shift_d = bus.i_rd_data;
        end

        if (startDet) begin
            state_d  = ADDR;
            bitCnt_d = 3'd7;
            sdaOe_d  = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (stopDet) begin
            state_d  = IDLE;
            bitCnt_d = 3'd7;
            sdaOe_d  = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdaOe_d = 1'b0;
                end
                ADDR: begin
                    if (sclRise) begin
                        shift_d = {shift_q[6:0], sdaS};
                        if (bitCnt_q == 3'd0) begin
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = sdaS;
                                first_d = 1'b1;
                                phase_d = 1'b0;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!phase_q) begin
                            sdaOe_d = driveLow(ACK);
                            phase_d = 1'b1;
                            if (rw_q == RW_READ) begin
                                rdReq_d  = 1'b1;
                                rdLoad_d = 1'b1;
                            end
                        end else begin
                            phase_d  = 1'b0;
                            bitCnt_d = 3'd7;
                            if (rw_q == RW_READ) begin
                                sdaOe_d = driveLow(shift_q[7]);
                                state_d = RD_DATA;
                            end else begin
                                sdaOe_d = 1'b0;
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (sclRise) begin
                        shift_d = {shift_q[6:0], sdaS};
                        if (bitCnt_q == 3'd0) begin
                            wrData_d  = {shift_q[6:0], sdaS};
                            wrValid_d = 1'b1;
                            wrFirst_d = first_q;
                            first_d   = 1'b0;
                            phase_d   = 1'b0;
                            state_d   = WR_ACK;
                        end else begin
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (sclFall) begin
                        if (!phase_q) begin
                            sdaOe_d = driveLow(ACK);
                            phase_d = 1'b1;
                        end else begin
                            sdaOe_d  = 1'b0;
                            phase_d  = 1'b0;
                            bitCnt_d = 3'd7;
                            state_d  = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 3'd0) begin
                            sdaOe_d = 1'b0;
                            phase_d = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sdaOe_d  = driveLow(shift_q[6]);
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (sclRise && !phase_q) begin
                        if (sdaS == ACK) begin
                            rdReq_d  = 1'b1;
                            rdLoad_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = WAIT_STOP;
                        end
                    end else if (sclFall && phase_q) begin
                        sdaOe_d  = driveLow(shift_q[7]);
                        bitCnt_d = 3'd7;
                        phase_d  = 1'b0;
                        state_d  = RD_DATA;
                    end
                end
                WAIT_STOP: begin
                    sdaOe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    sdaOe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe     = sdaOe_q;
    assign bus.o_wr_data  = wrData_q;
    assign bus.o_wr_valid = wrValid_q;
    assign bus.o_wr_first = wrFirst_q;
    assign bus.o_rd_req   = rdReq_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_nack     = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master, a register backend and a
// transaction-level model of what the target should report.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } wrEvt_t;

    logic i_clk = 1'b0;
    logic reset;
    logic sclDrv;
    logic sdaDrv;

    always #5 i_clk = ~i_clk;

    i2c_slave_if bus();

    assign bus.scl_i = sclDrv;
    assign bus.sda_i = sdaDrv & ~bus.sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h4B), .SYNC_STAGES(2)) dut (
        .i_clk (i_clk),
        .reset (reset),
        .bus   (bus)
    );

    int         errors = 0;
    int         checks = 0;
    wrEvt_t     wrQ[$];
    wrEvt_t     expWr [0:255];
    int         expCnt = 0;
    int         wrChk = 0;
    logic [7:0] rdBack [0:255];
    int         rdReqCnt = 0;
    int         nackCnt = 0;
    int         oeCount = 0;
    int         protoViol = 0;
    logic [7:0] txBuf [0:3];
    logic [7:0] rdBuf [0:3];

    // Backend and observer: records writes, serves reads, counts pulses.
    always @(negedge i_clk) begin
        if (bus.o_wr_valid) wrQ.push_back('{data: bus.o_wr_data, first: bus.o_wr_first});
        if (bus.o_rd_req) begin
            bus.i_rd_data = rdBack[rdReqCnt % 256];
            rdReqCnt++;
        end
        if (bus.o_nack) nackCnt++;
        if (bus.sda_oe) oeCount++;
        if ((bus.o_wr_valid && bus.o_rd_req) ||
            ((bus.o_wr_valid || bus.o_rd_req) && !bus.o_busy)) protoViol++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitQ();
        repeat (Q) @(negedge i_clk);
    endtask

    task automatic i2cStart();
        sdaDrv = 1'b1; waitQ();
        sclDrv = 1'b1; waitQ();
        sdaDrv = 1'b0; waitQ();
        sclDrv = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        sdaDrv = 1'b0; waitQ();
        sclDrv = 1'b1; waitQ();
        sdaDrv = 1'b1; waitQ();
        waitQ();
    endtask

    task automatic writeBit(input logic b);
        sdaDrv = b; waitQ();
        sclDrv = 1'b1; waitQ(); waitQ();
        sclDrv = 1'b0; waitQ();
    endtask

    task automatic readBit(output logic b);
        sdaDrv = 1'b1; waitQ();
        sclDrv = 1'b1; waitQ();
        b = bus.sda_i; waitQ();
        sclDrv = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            readBit(b);
            d = {d[6:0], b};
        end
        writeBit(masterAck);
    endtask

    task automatic glitchLow();
        for (int g = 0; g < 4; g++) begin
            sdaDrv = ~sdaDrv;
            repeat (2) @(negedge i_clk);
        end
    endtask

    task automatic expectWrite(input logic [7:0] d, input logic f);
        expWr[expCnt] = '{data: d, first: f};
        expCnt++;
    endtask

    // Write transaction without STOP: only the configured address is ACKed,
    // and every accepted byte is reported with first set on the sub-address.
    task automatic applyStimulus(input logic [6:0] addr, input int n);
        logic ack;
        logic expAck;
        expAck = (addr == 7'h4B) ? ACK : NACK;
        i2cStart();
        writeByte({addr, RW_WRITE}, ack);
        checkOutput("addrAck", 32'(ack), 32'(expAck));
        if (expAck == ACK) begin
            for (int k = 0; k < n; k++) begin
                writeByte(txBuf[k], ack);
                checkOutput("dataAck", 32'(ack), 32'(ACK));
                expectWrite(txBuf[k], (k == 0));
            end
        end
    endtask

    // Read transaction (START or repeated START), master NACKs the last byte.
    task automatic doRead(input int n);
        int         base;
        int         nb;
        logic       ack;
        logic [7:0] d;
        base = rdReqCnt;
        nb   = nackCnt;
        for (int k = 0; k < n; k++) rdBack[(base + k) % 256] = rdBuf[k];
        i2cStart();
        writeByte({7'h4B, RW_READ}, ack);
        checkOutput("rdAddrAck", 32'(ack), 32'(ACK));
        for (int k = 0; k < n; k++) begin
            readByte((k == n - 1) ? NACK : ACK, d);
            checkOutput("rdData", 32'(d), 32'(rdBuf[k]));
        end
        checkOutput("rdReqCount", 32'(rdReqCnt - base), 32'(n));
        checkOutput("nackPulse", 32'(nackCnt - nb), 32'd1);
        checkOutput("rdRelease", 32'(bus.sda_oe), 32'd0);
    endtask

    task automatic verifyWrites();
        checkOutput("wrCount", 32'(wrQ.size()), 32'(expCnt));
        while (wrChk < expCnt && wrChk < wrQ.size()) begin
            checkOutput($sformatf("wrData%0d", wrChk), 32'(wrQ[wrChk].data), 32'(expWr[wrChk].data));
            checkOutput($sformatf("wrFirst%0d", wrChk), 32'(wrQ[wrChk].first), 32'(expWr[wrChk].first));
            wrChk++;
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({bus.sda_oe, bus.o_wr_data, bus.o_wr_valid, bus.o_wr_first,
                    bus.o_rd_req, bus.o_busy, bus.o_nack});
    endfunction

    initial begin
        logic       ack;
        int         cnt;
        int         oeBase;
        int         kind;
        int         n;
        logic [6:0] addr;

        sclDrv = 1'b1;
        sdaDrv = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("resetOutputs", allOutputs(), 32'd0);
        reset = 1'b0;
        waitQ();

        $display("[TB] write 0x4B: 0x2E 0xFE 0x07");
        txBuf[0] = 8'h2E; txBuf[1] = 8'hFE; txBuf[2] = 8'h07;
        applyStimulus(7'h4B, 3);
        checkOutput("busyDuringWrite", 32'(bus.o_busy), 32'd1);
        i2cStop();
        checkOutput("busyAfterStop", 32'(bus.o_busy), 32'd0);
        verifyWrites();

        $display("[TB] address mismatch 0x3A");
        oeBase = oeCount;
        txBuf[0] = 8'h55;
        applyStimulus(7'h3A, 1);
        checkOutput("mismatchNoPull", 32'(oeCount - oeBase), 32'd0);
        checkOutput("mismatchBusy", 32'(bus.o_busy), 32'd0);
        i2cStop();
        verifyWrites();

        $display("[TB] sub-address write then repeated-START read");
        txBuf[0] = 8'h2E;
        rdBuf[0] = 8'hBE; rdBuf[1] = 8'hEF;
        applyStimulus(7'h4B, 1);
        doRead(2);
        i2cStop();
        verifyWrites();
        checkOutput("busyAfterRead", 32'(bus.o_busy), 32'd0);

        $display("[TB] STOP after four bits of a data byte");
        i2cStart();
        writeByte({7'h4B, RW_WRITE}, ack);
        checkOutput("abortAddrAck", 32'(ack), 32'(ACK));
        writeByte(8'h11, ack);
        expectWrite(8'h11, 1'b1);
        for (int i = 0; i < 4; i++) writeBit(1'($urandom));
        i2cStop();
        checkOutput("abortBusy", 32'(bus.o_busy), 32'd0);
        verifyWrites();
        txBuf[0] = 8'hA5; txBuf[1] = 8'h3C;
        applyStimulus(7'h4B, 2);
        i2cStop();
        verifyWrites();

        $display("[TB] reset during address ACK");
        i2cStart();
        for (int i = 7; i >= 0; i--) writeBit(((8'h4B << 1) >> i) & 1);
        cnt = 0;
        while (!bus.sda_oe && cnt < 40) begin
            @(negedge i_clk);
            cnt++;
        end
        checkOutput("ackDrivenBeforeReset", 32'(bus.sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("resetAsyncOe", 32'(bus.sda_oe), 32'd0);
        checkOutput("resetMidOutputs", allOutputs(), 32'd0);
        repeat (3) @(negedge i_clk);
        reset = 1'b0;
        readBit(ack);
        i2cStop();
        verifyWrites();

        $display("[TB] ACK hold time and SDA glitches while SCL low");
        i2cStart();
        for (int i = 7; i >= 1; i--) writeBit(((8'h4B << 1) >> i) & 1);
        sdaDrv = RW_WRITE; waitQ();
        sclDrv = 1'b1; waitQ(); waitQ();
        sclDrv = 1'b0;
        cnt = 0;
        while (!bus.sda_oe && cnt < 20) begin
            @(posedge i_clk);
            #1;
            cnt++;
        end
        checkOutput("ackHoldClocks", 32'(cnt), 32'd3);
        @(negedge i_clk);
        readBit(ack);
        checkOutput("holdAddrAck", 32'(ack), 32'(ACK));
        glitchLow();
        txBuf[0] = 8'($urandom);
        writeByte(txBuf[0], ack);
        checkOutput("glitchDataAck", 32'(ack), 32'(ACK));
        expectWrite(txBuf[0], 1'b1);
        checkOutput("glitchBusy", 32'(bus.o_busy), 32'd1);
        glitchLow();
        checkOutput("glitchBusy2", 32'(bus.o_busy), 32'd1);
        i2cStop();
        verifyWrites();

        $display("[TB] randomized transactions");
        for (int it = 0; it < 14; it++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                txBuf[k] = 8'($urandom);
                rdBuf[k] = 8'($urandom);
            end
            case (kind)
                0: begin
                    addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h4B;
                    applyStimulus(addr, n);
                    i2cStop();
                end
                1: begin
                    doRead(n);
                    i2cStop();
                end
                default: begin
                    applyStimulus(7'h4B, 1);
                    doRead(n);
                    i2cStop();
                end
            endcase
            verifyWrites();
            checkOutput("randBusyAfterStop", 32'(bus.o_busy), 32'd0);
        end

        checkOutput("pulseRules", 32'(protoViol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
